tlb_ctrl: RTL
=============

Name: tlb_ctrl

Overview:
- Sits beside the 16-entry TLB array, between the WB-stage CP0/exception logic and the array's s1 search, read and write ports.
- Owns the CP0 TLB registers: Index (0), EntryLo0 (2), EntryLo1 (3) and EntryHi (10).
- Sequences TLBP, TLBR and TLBWI, and captures the faulting address into EntryHi on TLB exceptions.

Parameters:
TLBNUM, 16, number of TLB entries; IDXW = $clog2(TLBNUM)

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
op_valid  input  1  TLB instruction request from WB
op_code  input  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 reserved (ignored, never accepted)
op_ready  output  1  high only in IDLE
op_done  output  1  one-cycle pulse on completion; also pipeline refetch request
mtc0_we  input  1  CP0 write strobe
c0_addr  input  5  CP0 register number for mtc0/mfc0
c0_wdata  input  32  mtc0 data
c0_rdata  output  32  combinational mfc0 data (0 for unowned numbers)
exc_tlb  input  1  TLB refill/invalid/modified exception committing this cycle
exc_badvaddr  input  32  faulting virtual address
probe_sel  output  1  high in PROBE; steers the s1 mux toward this block
s1_vpn2/s1_odd_page/s1_asid  output  19/1/8  = EntryHi[31:13], 0, EntryHi[7:0]
s1_found/s1_index  input  1/IDXW  search result
entryhi_asid  output  8  current ASID, for the s0/s1 fetch and data lookups
we/w_index  output  1/IDXW  array write
w_vpn2/w_asid/w_g/w_pfn0/w_c0/w_d0/w_v0/w_pfn1/w_c1/w_d1/w_v1  output  19/8/1/20/3/1/1/20/3/1/1  write data
r_index  output  IDXW  = Index[IDXW-1:0]
r_vpn2/r_asid/r_g/r_pfn0/r_c0/r_d0/r_v0/r_pfn1/r_c1/r_d1/r_v1  input  same widths  read data

Behaviour:
- Register formats
  - Index: P[31], index[IDXW-1:0]; other bits read 0. mtc0 writes only the index bits; P is hardware-written only.
  - EntryHi: VPN2[31:13], ASID[7:0]; bits 12:8 read 0.
  - EntryLo0/1: PFN[25:6], C[5:3], D[2], V[1], G[0]; bits 31:26 read 0.
- Reset: all four registers 0, state IDLE, op_ready=1, op_done=0, we=0, probe_sel=0.
- FSM states IDLE, PROBE, READ, WRITE.
  - IDLE: op_valid && op_ready && !exc_tlb && op_code != 11 moves to PROBE, READ or WRITE respectively.
  - Every op state lasts exactly 1 cycle, asserts op_done, then returns to IDLE.
  - Latency: op_done is asserted the cycle after acceptance; register updates are visible the cycle after op_done.
- PROBE:
  - probe_sel=1.
  - At the clock edge: found → Index = {0, s1_index}; not found → P=1 and the index bits are unchanged.
- READ:
  - At the edge: EntryHi = {r_vpn2, 5'b0, r_asid}.
  - EntryLo0 = {6'b0, r_pfn0, r_c0, r_d0, r_v0, r_g}; EntryLo1 likewise from the *1 fields.
- WRITE:
  - we=1 combinationally, with w_index = Index bits and fields taken from EntryHi/EntryLo0/EntryLo1.
  - w_g = EntryLo0.G & EntryLo1.G.
- Outside WRITE, we=0.
- exc_tlb behaviour:
  - EntryHi.VPN2 ← exc_badvaddr[31:13]; ASID is preserved.
  - Highest priority, over both mtc0 and op updates.
  - In IDLE: blocks acceptance.
  - In an op state: aborts the op. we is forced 0, no Index/Entry update, no op_done, return to IDLE.
- mtc0 is accepted in any state. If an op updates the same register on the same edge, the op update wins.
- c0_rdata reflects register contents before the current edge.
- op_valid held while busy is simply re-evaluated in IDLE; one acceptance per handshake.

Test Plan:
- Reset mid-WRITE (resetn low) → we drops to 0 immediately; all registers read 0; op_ready=1.
- TLBWI: mtc0 EntryHi=0x00402005, Lo0=0x00001047, Lo1=0x00001086, Index=3, then TLBWI.
  - Required: we=1 for exactly one cycle, w_index=3, w_vpn2=0x201, w_asid=0x05.
  - w_pfn0=0x41, w_pfn1=0x42, d/v = 1/1 for both pages, w_g=0.
  - op_done pulses in the same cycle.
- TLBP hit: after the TLBWI above, TLBP with EntryHi=0x00402005 → Index=0x00000003.
- TLBP miss: TLBP with ASID 0x06 → Index=0x80000003, probe_sel high for one cycle.
- TLBR: entry 3 holds g=1, vpn2=0x201, asid=0x05, Index=3; TLBR → EntryHi=0x00402005, EntryLo0[0]=1, EntryLo1[0]=1.
- Exception priority:
  - exc_tlb with badvaddr=0x12345678, same cycle as mtc0 EntryHi=0xFFFFFFFF, prior ASID 0x05 → EntryHi=0x12344005.
  - exc_tlb asserted during the WRITE cycle → we=0, no op_done, state returns to IDLE.

Source files
------------

// File: rtl/tlb_ctrl_if.sv
// ---------------------------------------------------------------------------
// tlb_ctrl_if
//   WB-stage side of the TLB controller: TLB instruction handshake, CP0
//   mtc0/mfc0 access and TLB exception commit.
//
//   master : the WB / CP0 pipeline logic (drives requests, mtc0, exceptions)
//   slave  : tlb_ctrl (answers the handshake, returns mfc0 data)
//
//   op_valid/op_code   TLB instruction request (00 TLBP, 01 TLBR, 10 TLBWI)
//   op_ready/op_done   controller idle / one-cycle completion pulse
//   mtc0_we/c0_addr/c0_wdata/c0_rdata   CP0 register write and read
//   exc_tlb/exc_badvaddr                TLB exception commit + faulting VA
// ---------------------------------------------------------------------------
interface tlb_ctrl_if;
    logic        op_valid;
    logic [1:0]  op_code;
    logic        op_ready;
    logic        op_done;
    logic        mtc0_we;
    logic [4:0]  c0_addr;
    logic [31:0] c0_wdata;
    logic [31:0] c0_rdata;
    logic        exc_tlb;
    logic [31:0] exc_badvaddr;

    modport master (
        output op_valid, op_code, mtc0_we, c0_addr, c0_wdata, exc_tlb, exc_badvaddr,
        input  op_ready, op_done, c0_rdata
    );

    modport slave (
        input  op_valid, op_code, mtc0_we, c0_addr, c0_wdata, exc_tlb, exc_badvaddr,
        output op_ready, op_done, c0_rdata
    );
endinterface

// File: rtl/tlb_ctrl.sv
// ---------------------------------------------------------------------------
// tlb_ctrl
//   Owns the CP0 TLB registers (Index, EntryLo0, EntryLo1, EntryHi) and
//   sequences TLBP / TLBR / TLBWI against the TLB array's s1 search port,
//   read port and write port. On a committed TLB exception the faulting
//   VPN2 is captured into EntryHi.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   wb                   WB-side handshake / CP0 access (tlb_ctrl_if.slave)
//   probe_sel            high in PROBE; steers the array's s1 mux here
//   s1_vpn2/odd/asid     search key (EntryHi VPN2, even page, EntryHi ASID)
//   s1_found/s1_index    search result
//   entryhi_asid         current ASID for the fetch/data lookups
//   we/w_index/w_*       array write port (TLBWI)
//   r_index/r_*          array read port (TLBR)
// ---------------------------------------------------------------------------
module tlb_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,
    tlb_ctrl_if.slave       wb,

    // s1 search port
    output logic            probe_sel,
    output logic [18:0]     s1_vpn2,
    output logic            s1_odd_page,
    output logic [7:0]      s1_asid,
    input  logic            s1_found,
    input  logic [IDXW-1:0] s1_index,

    output logic [7:0]      entryhi_asid,

    // write port
    output logic            we,
    output logic [IDXW-1:0] w_index,
    output logic [18:0]     w_vpn2,
    output logic [7:0]      w_asid,
    output logic            w_g,
    output logic [19:0]     w_pfn0,
    output logic [2:0]      w_c0,
    output logic            w_d0,
    output logic            w_v0,
    output logic [19:0]     w_pfn1,
    output logic [2:0]      w_c1,
    output logic            w_d1,
    output logic            w_v1,

    // read port
    output logic [IDXW-1:0] r_index,
    input  logic [18:0]     r_vpn2,
    input  logic [7:0]      r_asid,
    input  logic            r_g,
    input  logic [19:0]     r_pfn0,
    input  logic [2:0]      r_c0,
    input  logic            r_d0,
    input  logic            r_v0,
    input  logic [19:0]     r_pfn1,
    input  logic [2:0]      r_c1,
    input  logic            r_d1,
    input  logic            r_v1
);

    localparam logic [4:0] C0_INDEX = 5'd0;
    localparam logic [4:0] C0_LO0   = 5'd2;
    localparam logic [4:0] C0_LO1   = 5'd3;
    localparam logic [4:0] C0_HI    = 5'd10;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // CP0 register storage (only the implemented bits are kept)
    logic            index_p_reg;
    logic [IDXW-1:0] index_reg;
    logic [18:0]     hi_vpn2_reg;
    logic [7:0]      hi_asid_reg;
    logic [1:0][25:0] lo_q;      // EntryLo0/1 bits [25:0]: PFN, C, D, V, G
    logic [1:0][25:0] r_lo;      // read-port data in EntryLo layout

    logic op_ready_c;
    logic op_done_c;
    logic we_c;
    logic probe_sel_c;

    // An op commits its register update only when no exception aborts it.
    logic do_probe;
    logic do_read;
    logic mtc0_ok;

    assign do_probe = (state_reg == PROBE) && !wb.exc_tlb;
    assign do_read  = (state_reg == READ)  && !wb.exc_tlb;
    // An instruction that raises a TLB exception does not retire, so its
    // mtc0 (if any) must not land in any register either.
    assign mtc0_ok  = wb.mtc0_we && !wb.exc_tlb;

    // Low bits of the faulting address never reach EntryHi.
    logic [12:0] unused_badvaddr_lo;
    assign unused_badvaddr_lo = wb.exc_badvaddr[12:0];

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_ready_c  = 1'b0;
        op_done_c   = 1'b0;
        we_c        = 1'b0;
        probe_sel_c = 1'b0;
        unique case (state_reg)
            IDLE: begin
                op_ready_c = 1'b1;
                if (wb.op_valid && !wb.exc_tlb) begin
                    case (wb.op_code)
                        OP_TLBP:  state_next = PROBE;
                        OP_TLBR:  state_next = READ;
                        OP_TLBWI: state_next = WRITE;
                        default:  state_next = IDLE;   // reserved code: never accepted
                    endcase
                end
            end
            PROBE: begin
                probe_sel_c = 1'b1;
                op_done_c   = !wb.exc_tlb;
                state_next  = IDLE;
            end
            READ: begin
                op_done_c  = !wb.exc_tlb;
                state_next = IDLE;
            end
            WRITE: begin
                // An exception in the same cycle must not corrupt the array.
                we_c       = !wb.exc_tlb;
                op_done_c  = !wb.exc_tlb;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wb.op_ready = op_ready_c;
    assign wb.op_done  = op_done_c;
    assign we          = we_c;
    assign probe_sel   = probe_sel_c;

    // -----------------------------------------------------------------------
    // Index: P is written only by TLBP; mtc0 reaches the index bits only.
    // The op update is placed after mtc0 so it wins on a shared edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_p_reg <= 1'b0;
            index_reg   <= '0;
        end else begin
            if (mtc0_ok && wb.c0_addr == C0_INDEX) begin
                index_reg <= wb.c0_wdata[IDXW-1:0];
            end
            if (do_probe) begin
                if (s1_found) begin
                    index_p_reg <= 1'b0;
                    index_reg   <= s1_index;
                end else begin
                    index_p_reg <= 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // EntryHi: exception capture overrides everything but keeps the ASID.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_vpn2_reg <= '0;
            hi_asid_reg <= '0;
        end else if (wb.exc_tlb) begin
            hi_vpn2_reg <= wb.exc_badvaddr[31:13];
        end else begin
            if (mtc0_ok && wb.c0_addr == C0_HI) begin
                hi_vpn2_reg <= wb.c0_wdata[31:13];
                hi_asid_reg <= wb.c0_wdata[7:0];
            end
            if (do_read) begin
                hi_vpn2_reg <= r_vpn2;
                hi_asid_reg <= r_asid;
            end
        end
    end

    // -----------------------------------------------------------------------
    // EntryLo0 / EntryLo1: identical behaviour, one register per page.
    // -----------------------------------------------------------------------
    assign r_lo[0] = {r_pfn0, r_c0, r_d0, r_v0, r_g};
    assign r_lo[1] = {r_pfn1, r_c1, r_d1, r_v1, r_g};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lo
            localparam logic [4:0] LO_ADDR = (gi == 0) ? C0_LO0 : C0_LO1;
            logic [25:0] lo_reg;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    lo_reg <= '0;
                end else begin
                    if (mtc0_ok && wb.c0_addr == LO_ADDR) begin
                        lo_reg <= wb.c0_wdata[25:0];
                    end
                    if (do_read) begin
                        lo_reg <= r_lo[gi];
                    end
                end
            end

            assign lo_q[gi] = lo_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // mfc0 read mux (register contents before the current edge)
    // -----------------------------------------------------------------------
    always_comb begin
        wb.c0_rdata = 32'd0;
        case (wb.c0_addr)
            C0_INDEX: wb.c0_rdata = {index_p_reg, {(31-IDXW){1'b0}}, index_reg};
            C0_LO0:   wb.c0_rdata = {6'd0, lo_q[0]};
            C0_LO1:   wb.c0_rdata = {6'd0, lo_q[1]};
            C0_HI:    wb.c0_rdata = {hi_vpn2_reg, 5'd0, hi_asid_reg};
            default:  wb.c0_rdata = 32'd0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Array-facing fields
    // -----------------------------------------------------------------------
    assign s1_vpn2      = hi_vpn2_reg;
    assign s1_odd_page  = 1'b0;
    assign s1_asid      = hi_asid_reg;
    assign entryhi_asid = hi_asid_reg;

    assign w_index = index_reg;
    assign w_vpn2  = hi_vpn2_reg;
    assign w_asid  = hi_asid_reg;
    // An entry is global only if both halves say so.
    assign w_g     = lo_q[0][0] & lo_q[1][0];
    assign w_pfn0  = lo_q[0][25:6];
    assign w_c0    = lo_q[0][5:3];
    assign w_d0    = lo_q[0][2];
    assign w_v0    = lo_q[0][1];
    assign w_pfn1  = lo_q[1][25:6];
    assign w_c1    = lo_q[1][5:3];
    assign w_d1    = lo_q[1][2];
    assign w_v1    = lo_q[1][1];

    assign r_index = index_reg;

endmodule
